// File: rtl/alu_downsample_seq_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : alu_downsample_seq_if                                  |
// | Description : Sample-in, result-out and ALU operand/result bundle    |
// |               shared between the downsampling sequencer and its      |
// |               environment (sample source, result sink, 20-bit ALU).  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface alu_downsample_seq_if;
    logic [19:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic [3:0]  alu_ctrl;
    logic [19:0] alu_ac;
    logic [19:0] alu_in;
    logic [19:0] alu_out;
    logic [19:0] result;
    logic        result_valid;
    logic        result_ready;

    // Sequencer side
    modport master (
        output sample_ready, alu_ctrl, alu_ac, alu_in, result, result_valid,
        input  sample_data, sample_valid, alu_out, result_ready
    );

    // Environment side (source, sink and ALU)
    modport slave (
        input  sample_ready, alu_ctrl, alu_ac, alu_in, result, result_valid,
        output sample_data, sample_valid, alu_out, result_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_downsample_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : alu_downsample_seq                                     |
// | Description : Drives an external 20-bit ALU to average WINDOW        |
// |               samples per window (clear, accumulate, shift, emit)    |
// |               for NUM_WINDOWS windows per start pulse.               |
// |               Optional macro ALU_SEQ_SAT_EN: saturating accumulation |
// |               plus a sticky sat_flag output.                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu_downsample_seq #(
    parameter int          WINDOW      = 64,
    parameter int          NUM_WINDOWS = 16,
    parameter logic [3:0]  DIV_CODE    = 4'b0100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    alu_downsample_seq_if.master   seqBus,
    output logic                   busy,
    output logic                   done
`ifdef ALU_SEQ_SAT_EN
    ,
    output logic                   sat_flag
`endif
);

    localparam int         c_CNT_W   = $clog2(WINDOW + 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_CLR     = 3'd1;
    localparam logic [2:0] c_ACC     = 3'd2;
    localparam logic [2:0] c_DIV     = 3'd3;
    localparam logic [2:0] c_OUT     = 3'd4;

    localparam logic [3:0] c_OP_PASS = 4'b0001;
    localparam logic [3:0] c_OP_ADD  = 4'b0010;
    localparam logic [3:0] c_OP_CLR  = 4'b1110;

    logic [2:0]         r_state;
    logic [2:0]         w_nextState;
    logic [19:0]        r_ac;
    logic [19:0]        r_result;
    logic [c_CNT_W-1:0] r_sampleCnt;
    logic [15:0]        r_windowCnt;
    logic               r_done;
    logic               w_accept;
    logic               w_lastSample;
    logic               w_lastWindow;
    logic               w_abortActive;
    logic [19:0]        w_accNext;

    // Samples are only taken in ACC, so the accept condition needs no ready term
    assign w_accept      = (r_state == c_ACC) && seqBus.sample_valid;
    assign w_lastSample  = (r_sampleCnt == c_CNT_W'(WINDOW - 1));
    assign w_lastWindow  = (r_windowCnt == 16'(NUM_WINDOWS - 1));
    assign w_abortActive = abort && (r_state != c_IDLE);

`ifdef ALU_SEQ_SAT_EN
    logic w_overflow;
    logic r_sat;

    // An unsigned add that wrapped produces a sum smaller than the AC operand
    assign w_overflow = w_accept && (seqBus.alu_out < r_ac);
    assign w_accNext  = w_overflow ? 20'hFFFFF : seqBus.alu_out;
    assign sat_flag   = r_sat;

    // Sticky saturation indicator, reset at the start of each window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat <= 1'b0;
        end else if (w_abortActive) begin
            r_sat <= r_sat;
        end else if (r_state == c_CLR) begin
            r_sat <= 1'b0;
        end else if (w_overflow) begin
            r_sat <= 1'b1;
        end
    end
`else
    assign w_accNext = seqBus.alu_out;
`endif

    assign seqBus.alu_ac = r_ac;
    assign seqBus.result = r_result;
    assign done          = r_done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; abort overrides every non-idle transition
    always_comb begin
        w_nextState = r_state;
        if (w_abortActive) begin
            w_nextState = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  if (start && !abort) w_nextState = c_CLR;
                c_CLR:   w_nextState = c_ACC;
                c_ACC:   if (w_accept && w_lastSample) w_nextState = c_DIV;
                c_DIV:   w_nextState = c_OUT;
                c_OUT:   if (seqBus.result_ready) w_nextState = w_lastWindow ? c_IDLE : c_CLR;
                default: w_nextState = c_IDLE;
            endcase
        end
    end

    // Handshake and ALU drive decoded from the current state
    always_comb begin
        seqBus.sample_ready = 1'b0;
        seqBus.result_valid = 1'b0;
        seqBus.alu_ctrl     = c_OP_PASS;
        seqBus.alu_in       = 20'd0;
        busy                = (r_state != c_IDLE);
        case (r_state)
            c_CLR: seqBus.alu_ctrl = c_OP_CLR;
            c_ACC: begin
                seqBus.sample_ready = 1'b1;
                seqBus.alu_in       = seqBus.sample_data;
                seqBus.alu_ctrl     = seqBus.sample_valid ? c_OP_ADD : c_OP_PASS;
            end
            c_DIV: seqBus.alu_ctrl = DIV_CODE;
            c_OUT: seqBus.result_valid = 1'b1;
            default: ;
        endcase
    end

    // Accumulator, counters, result register and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ac        <= 20'd0;
            r_result    <= 20'd0;
            r_sampleCnt <= '0;
            r_windowCnt <= 16'd0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abortActive) begin
                r_ac        <= 20'd0;
                r_sampleCnt <= '0;
                r_windowCnt <= 16'd0;
            end else begin
                case (r_state)
                    c_IDLE: if (start && !abort) r_windowCnt <= 16'd0;
                    c_CLR: begin
                        r_ac        <= seqBus.alu_out;
                        r_sampleCnt <= '0;
                    end
                    c_ACC: if (w_accept) begin
                        r_ac        <= w_accNext;
                        r_sampleCnt <= r_sampleCnt + c_CNT_W'(1);
                    end
                    c_DIV: begin
                        r_ac     <= seqBus.alu_out;
                        r_result <= seqBus.alu_out;
                    end
                    c_OUT: if (seqBus.result_ready) begin
                        if (w_lastWindow) begin
                            r_done <= 1'b1;
                        end else begin
                            r_windowCnt <= r_windowCnt + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_downsample_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : tb_alu_downsample_seq                                  |
// | Description : Self-checking bench for alu_downsample_seq with an ALU |
// |               model, a window-average reference and vector table.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_alu_downsample_seq;

    localparam int WINDOW = 64;
    localparam int NW     = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy;
    logic done;
`ifdef ALU_SEQ_SAT_EN
    logic sat_flag;
`endif

    alu_downsample_seq_if bus();

    alu_downsample_seq #(
        .WINDOW      (WINDOW),
        .NUM_WINDOWS (NW),
        .DIV_CODE    (4'b0100)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .seqBus (bus),
        .busy   (busy),
        .done   (done)
`ifdef ALU_SEQ_SAT_EN
        ,
        .sat_flag (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    // External 20-bit ALU
    always_comb begin
        case (bus.alu_ctrl)
            4'b0001: bus.alu_out = bus.alu_ac;
            4'b0010: bus.alu_out = bus.alu_ac + bus.alu_in;
            4'b0100: bus.alu_out = bus.alu_ac >> 6;
            4'b1110: bus.alu_out = 20'd0;
            default: bus.alu_out = bus.alu_ac ^ bus.alu_in;
        endcase
    end

    typedef struct {
        logic [19:0] res;
        int          cnt;
        logic [19:0] exp;
        bit          expSat;
        bit          satSeen;
    } res_t;

    typedef struct {
        logic [19:0] base;
        logic [19:0] step;
        logic [19:0] expRes;
        bit          expSat;
    } vec_t;

    res_t        resQ[$];
    logic [3:0]  ctrlLog[$];
    int          badAcc  = 0;
    int          doneCnt = 0;
    longint      mSum    = 0;
    int          mCnt    = 0;
    bit          mSat    = 1'b0;
    res_t        rec;

    // Reference: window average of the accepted samples, sampled mid-cycle
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            mSum = 0; mCnt = 0; mSat = 1'b0;
        end else begin
            if (busy && bus.alu_ctrl != 4'b0001) ctrlLog.push_back(bus.alu_ctrl);
            if (done) doneCnt++;
            if (abort && busy) begin
                mSum = 0; mCnt = 0; mSat = 1'b0;
            end else begin
                if (bus.sample_valid && bus.sample_ready) begin
                    if (bus.result_valid) badAcc++;
                    mSum = mSum + longint'(bus.sample_data);
`ifdef ALU_SEQ_SAT_EN
                    if (mSum > 64'hFFFFF) begin mSum = 64'hFFFFF; mSat = 1'b1; end
`else
                    mSum = mSum % (longint'(1) << 20);
`endif
                    mCnt++;
                end
                if (bus.result_valid && bus.result_ready) begin
                    rec.res    = bus.result;
                    rec.cnt    = mCnt;
                    rec.exp    = 20'(mSum / WINDOW);
                    rec.expSat = mSat;
`ifdef ALU_SEQ_SAT_EN
                    rec.satSeen = sat_flag;
`else
                    rec.satSeen = 1'b0;
`endif
                    resQ.push_back(rec);
                    mSum = 0; mCnt = 0; mSat = 1'b0;
                end
            end
        end
    end

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Feeds one window (table entry ti, or random data when ti<0) and takes its result
    task automatic runWindow(input int ti, input int gap, input int hold, input bit chkLat);
        int idx; int cyc; int held; int holdErr; int lastK; bit got; logic [19:0] r0;
        idx = 0; cyc = 0; held = 0; holdErr = 0; lastK = -1; got = 1'b0; r0 = 20'd0;
        while (!got && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (chkLat && cyc == 1) chk("first sample_ready", {31'd0, bus.sample_ready}, 32'd1);
            if (idx < WINDOW) begin
                if (gap == 0 || $urandom_range(99) >= gap) begin
                    bus.sample_valid = 1'b1;
                    if (ti < 0) bus.sample_data = 20'($urandom);
                    else        bus.sample_data = tbl[ti].base + tbl[ti].step * 20'(idx);
                    if (bus.sample_ready) begin
                        idx++;
                        if (idx == WINDOW) lastK = cyc;
                    end
                end else begin
                    bus.sample_valid = 1'b0;
                    bus.sample_data  = 20'($urandom);
                end
            end else begin
                bus.sample_valid = (gap != 0);
                bus.sample_data  = 20'($urandom);
            end
            if (bus.result_valid) begin
                if (chkLat && held == 0) chk("result latency", cyc - lastK, 32'd2);
                if (held == 0) r0 = bus.result;
                else if (bus.result !== r0) holdErr++;
                if (held >= hold) begin bus.result_ready = 1'b1; got = 1'b1; end
                else bus.result_ready = 1'b0;
                held++;
            end else begin
                bus.result_ready = (hold == 0);
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL window timeout: got %0d accepts expected %0d", idx, WINDOW);
        end
        if (hold > 0) chk("result stable while stalled", holdErr, 32'd0);
    endtask

    // One complete start-to-done run of NW=2 windows
    task automatic runRun(input int ta, input int tb, input int gap, input int hold, input bit first);
        int r0; int c0; int d0; int bad; int ti; res_t rr;
        r0 = resQ.size(); c0 = ctrlLog.size(); d0 = doneCnt;
        @(negedge clk);
        start = 1'b1; bus.sample_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        if (first) begin
            chk("CLR sample_ready", {31'd0, bus.sample_ready}, 32'd0);
            chk("CLR alu_ctrl", {28'd0, bus.alu_ctrl}, 32'hE);
            chk("busy after start", {31'd0, busy}, 32'd1);
        end
        runWindow(ta, gap, hold, first);
        @(negedge clk);
        chk("no done mid-run", {31'd0, done}, 32'd0);
        runWindow(tb, gap, hold, 1'b0);
        bus.sample_valid = 1'b0;
        @(negedge clk);
        chk("done pulse", {31'd0, done}, 32'd1);
        chk("busy after run", {31'd0, busy}, 32'd0);
        chk("result_valid after run", {31'd0, bus.result_valid}, 32'd0);
        @(negedge clk);
        chk("done one cycle", {31'd0, done}, 32'd0);
        chk("done count per run", doneCnt - d0, 32'd1);
        chk("results per run", resQ.size() - r0, 32'd2);
        for (int k = 0; k < 2; k++) begin
            if (r0 + k < resQ.size()) begin
                rr = resQ[r0 + k];
                ti = (k == 0) ? ta : tb;
                if (ti >= 0) chk("result vs table", {12'd0, rr.res}, {12'd0, tbl[ti].expRes});
                chk("result vs model", {12'd0, rr.res}, {12'd0, rr.exp});
                chk("accepts per window", rr.cnt, WINDOW);
`ifdef ALU_SEQ_SAT_EN
                chk("sat_flag", {31'd0, rr.satSeen}, {31'd0, rr.expSat});
                if (ti >= 0) chk("sat vs table", {31'd0, rr.satSeen}, {31'd0, tbl[ti].expSat});
`endif
            end
        end
        chk("alu_ctrl op count", ctrlLog.size() - c0, 32'd132);
        if (ctrlLog.size() - c0 == 132) begin
            bad = 0;
            for (int w = 0; w < 2; w++) begin
                if (ctrlLog[c0 + 66*w] != 4'b1110) bad++;
                for (int j = 1; j <= 64; j++) if (ctrlLog[c0 + 66*w + j] != 4'b0010) bad++;
                if (ctrlLog[c0 + 66*w + 65] != 4'b0100) bad++;
            end
            chk("alu_ctrl sequence", bad, 32'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx; int cyc; int nres; int ndone;
        tbl[0] = '{20'd100,   20'd0, 20'd100,  1'b0};
        tbl[1] = '{20'd0,     20'd1, 20'd31,   1'b0};
        tbl[2] = '{20'd64,    20'd0, 20'd64,   1'b0};
        tbl[3] = '{20'd128,   20'd0, 20'd128,  1'b0};
`ifdef ALU_SEQ_SAT_EN
        tbl[4] = '{20'h10000, 20'd0, 20'h03FFF, 1'b1};
        tbl[5] = '{20'hFFFFF, 20'd0, 20'h03FFF, 1'b1};
`else
        tbl[4] = '{20'h10000, 20'd0, 20'h00000, 1'b0};
        tbl[5] = '{20'hFFFFF, 20'd0, 20'h03FFF, 1'b0};
`endif
        tbl[6] = '{20'd1000,  20'd3, 20'd1094, 1'b0};
        tbl[7] = '{20'd5,     20'd0, 20'd5,    1'b0};

        bus.sample_data  = 20'd0;
        bus.sample_valid = 1'b0;
        bus.result_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset sample_ready", {31'd0, bus.sample_ready}, 32'd0);
        chk("reset result_valid", {31'd0, bus.result_valid}, 32'd0);
        chk("reset result", {12'd0, bus.result}, 32'd0);
        chk("reset alu_ac", {12'd0, bus.alu_ac}, 32'd0);
        chk("reset alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd1);
        rst_n = 1'b1;

        runRun(0, 1, 0, 0, 1'b1);
        runRun(2, 3, 0, 0, 1'b0);
        runRun(4, 5, 30, 10, 1'b0);
        runRun(6, 7, 40, 3, 1'b0);

        // Abort partway through the first window
        nres = resQ.size(); ndone = doneCnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        idx = 0; cyc = 0;
        while (idx < 30 && cyc < 500) begin
            @(negedge clk); cyc++;
            bus.sample_valid = 1'b1; bus.sample_data = 20'd9;
            if (bus.sample_ready) idx++;
        end
        @(negedge clk);
        bus.sample_valid = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort sample_ready", {31'd0, bus.sample_ready}, 32'd0);
        chk("abort result_valid", {31'd0, bus.result_valid}, 32'd0);
        chk("abort clears AC", {12'd0, bus.alu_ac}, 32'd0);
        repeat (5) @(negedge clk);
        chk("abort no result", resQ.size() - nres, 32'd0);
        chk("abort no done", doneCnt - ndone, 32'd0);
        runRun(7, 7, 0, 0, 1'b0);

        // start together with abort in IDLE
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("start+abort stays idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("start+abort still idle", {31'd0, busy}, 32'd0);

        for (int r = 0; r < 3; r++) runRun(-1, -1, $urandom_range(0, 50), $urandom_range(0, 5), 1'b0);
        runRun(2, 3, 0, 0, 1'b0);

        // Asynchronous reset in the middle of accumulation
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) begin
            @(negedge clk);
            bus.sample_valid = 1'b1; bus.sample_data = 20'd77;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async reset busy", {31'd0, busy}, 32'd0);
        chk("async reset sample_ready", {31'd0, bus.sample_ready}, 32'd0);
        chk("async reset result", {12'd0, bus.result}, 32'd0);
        chk("async reset alu_ac", {12'd0, bus.alu_ac}, 32'd0);
        chk("async reset result_valid", {31'd0, bus.result_valid}, 32'd0);
        bus.sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        runRun(-1, 1, 25, 4, 1'b0);

        chk("accepts while result pending", badAcc, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_downsample_seq.md
Name: alu_downsample_seq

Overview:
- Sequencer that drives the 20-bit ALU (4-bit control code, AC and InputBus operands, OutputBus result) to downsample a sample stream.
- Owns the accumulator register AC and implements per window: clear, add WINDOW samples through the ALU, divide via the ALU shift op, emit one result.
- Sits between the sample source (valid/ready) and the result consumer (valid/ready).
- Repeats for NUM_WINDOWS windows per start.

Parameters:
- WINDOW, 64, samples accumulated per window; must equal 2^6 to match DIV_CODE.
- NUM_WINDOWS, 16, windows processed per start pulse, range 1..65535.
- DIV_CODE, 4'b0100, ALU code used for the divide step (AC>>6).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a run; sampled only in IDLE
- abort  input  1  synchronous abort; return to IDLE next cycle
- sample_data  input  20  incoming sample
- sample_valid  input  1  sample_data valid
- sample_ready  output  1  sequencer accepts a sample this cycle
- alu_ctrl  output  4  ALU ControlSignal
- alu_ac  output  20  ALU AC operand, driven from internal AC register
- alu_in  output  20  ALU InputBus operand
- alu_out  input  20  ALU OutputBus
- result  output  20  downsampled value
- result_valid  output  1  result available
- result_ready  input  1  consumer accepts result
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse after the last window's result handshake

Behaviour:
- Reset (async, rst_n=0) state and outputs:
  - state=IDLE, AC=0, sample count=0, window count=0, result=0.
  - result_valid=0, sample_ready=0, done=0, busy=0.
- ALU drive is Moore from state. alu_in=0 except in ACC. Default alu_ctrl=4'b0001 (pass AC).
- IDLE:
  - start=1 -> CLR; window count=0.
  - start while busy is ignored.
- CLR (1 cycle):
  - alu_ctrl=4'b1110, AC<=alu_out (0), sample count<=0 -> ACC.
- ACC:
  - sample_ready=1, alu_in=sample_data.
  - On sample_valid&sample_ready: alu_ctrl=4'b0010, AC<=alu_out (AC+sample, modulo 2^20), count++.
  - Without sample_valid: alu_ctrl=4'b0001, AC holds.
  - When the WINDOW-th sample is accepted -> DIV. No extra sample is accepted that cycle.
- DIV (1 cycle):
  - alu_ctrl=DIV_CODE, AC<=alu_out, result<=alu_out -> OUT.
- OUT:
  - result_valid=1; result stable until handshake.
  - On result_ready: if window count==NUM_WINDOWS-1 -> IDLE with done=1 for one cycle; else window count++ -> CLR.
- Latency: start -> first sample_ready 2 cycles; last sample accept -> result_valid 2 cycles (DIV then OUT).
- Minimum window time: WINDOW+3 cycles with continuous valid and immediate ready.
- abort:
  - Highest priority in every non-IDLE state; next cycle is IDLE.
  - sample_ready and result_valid go low; AC and counts are cleared; no done.
  - abort in IDLE has no effect.
- start and abort in the same IDLE cycle: abort wins; remain IDLE.
- Arithmetic is unsigned 20-bit. Carry out of the add is discarded (wrap) unless the optional feature is enabled.
- The ALU's Z/N outputs are unused.

Optional Feature:
- Macro: ALU_SEQ_SAT_EN.
- Defined:
  - In ACC, an accepted add whose unsigned true sum exceeds 20'hFFFFF (detected as alu_out < alu_ac) loads AC=20'hFFFFF.
  - AC stays saturated for the rest of the window.
  - Adds a port sat_flag (output, 1 bit): sticky, set on any saturation, cleared by reset or by CLR.
- Not defined:
  - AC wraps modulo 2^20.
  - No sat_flag port.

Test Plan:
- NUM_WINDOWS=1; 64 samples of 100, continuous valid, result_ready=1 -> result=100, one result_valid, done pulses one cycle after the handshake, busy low afterward.
- Samples 0..63 (sum 2016) -> result=31. Check alu_ctrl sequence: 1110, 64x 0010, 0100.
- Random valid gaps plus result_ready held low for 10 cycles:
  - No sample accepted outside ACC.
  - result holds at its value throughout.
  - Exactly 64 accepts per window.
- NUM_WINDOWS=2, window1 all 64, window2 all 128 -> results 64 then 128; single done after the second handshake.
- abort after 30 samples, then a fresh start with 64 samples of 5 -> IDLE within 1 cycle, no result, no done; following run gives result=5.
- rst_n low mid-ACC -> all outputs at reset values immediately.
- 64 samples of 20'h10000:
  - Without the macro: result=0.
  - With ALU_SEQ_SAT_EN: result=20'h03FFF, sat_flag=1.
